// File: rtl/tc_ram_2r1w.sv
// Two-read/one-write word RAM with byte-enable writes, write-first forwarding,
// a post-reset clear sequencer and a sticky out-of-range flag.
module tc_ram_2r1w #(
  parameter int UUID           = 0,
  parameter     NAME           = "",
  parameter int BIT_WIDTH      = 16,
  parameter int BIT_DEPTH      = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load0,
  input  logic [15:0]            address0,
  output logic [BIT_WIDTH-1:0]   out0,
  input  logic                   load1,
  input  logic [15:0]            address1,
  output logic [BIT_WIDTH-1:0]   out1,
  input  logic                   save,
  input  logic [15:0]            save_address,
  input  logic [BIT_WIDTH-1:0]   in,
  input  logic [BIT_WIDTH/8-1:0] byte_en,
  output logic                   busy,
  output logic                   error
);

  localparam int              NB    = BIT_WIDTH / 8;
  localparam int              AW    = (BIT_DEPTH > 2) ? $clog2(BIT_DEPTH) : 1;
  localparam logic [16:0]     DEPTH = 17'(BIT_DEPTH);
  localparam logic [AW-1:0]   LAST  = AW'(BIT_DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                state, state_nx;
  logic [AW-1:0]         ptr;
  logic [BIT_WIDTH-1:0]  mem [BIT_DEPTH];

  logic                  idle;
  logic                  rd0_in, rd1_in, wr_in;
  logic                  rd0_ok, rd1_ok, wr_ok;
  logic [AW-1:0]         ra0, ra1, wa;
  logic [BIT_WIDTH-1:0]  merged;
  logic [BIT_WIDTH-1:0]  rd0_d, rd1_d;
  logic                  err_d;

  assign idle = (state == S_IDLE);
  assign busy = (state == S_CLEAR);

  assign rd0_in = ({1'b0, address0} < DEPTH);
  assign rd1_in = ({1'b0, address1} < DEPTH);
  assign wr_in  = ({1'b0, save_address} < DEPTH);

  assign ra0 = address0[AW-1:0];
  assign ra1 = address1[AW-1:0];
  assign wa  = save_address[AW-1:0];

  assign rd0_ok = idle && load0 && rd0_in;
  assign rd1_ok = idle && load1 && rd1_in;
  assign wr_ok  = idle && save && wr_in;

  // State register and clear pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_CLEAR) ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == S_CLEAR && ptr == LAST) state_nx = S_IDLE;
  end

  // Word after applying the byte mask; both the stored value and the
  // write-first forwarding path use it.
  always_comb begin
    merged = mem[wa];
    for (int k = 0; k < NB; k++) begin
      if (byte_en[k]) merged[8*k +: 8] = in[8*k +: 8];
    end
  end

  always_comb begin
    rd0_d = '0;
    rd1_d = '0;
    if (rd0_ok) rd0_d = (wr_ok && address0 == save_address) ? merged : mem[ra0];
    if (rd1_ok) rd1_d = (wr_ok && address1 == save_address) ? merged : mem[ra1];
    err_d = error;
    if (idle && ((load0 && !rd0_in) || (load1 && !rd1_in) || (save && !wr_in)))
      err_d = 1'b1;
  end

  // NOTE: the array itself is never reset (it maps onto RAM macros); the
  // reset branch is empty so an edge that coincides with reset writes nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
    end else if (state == S_CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out0  <= '0;
      out1  <= '0;
      error <= 1'b0;
    end else begin
      out0  <= rd0_d;
      out1  <= rd1_d;
      error <= err_d;
    end
  end

endmodule

// File: tb/tb_tc_ram_2r1w.sv
// Self-checking bench for tc_ram_2r1w: random and directed traffic compared
// every cycle against a word-array model, plus literal expectations.
module tb_tc_ram_2r1w;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int NB = W / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load0 = 1'b0, load1 = 1'b0, save = 1'b0;
  logic [15:0]   address0 = '0, address1 = '0, save_address = '0;
  logic [W-1:0]  din = '0;
  logic [NB-1:0] byte_en = '0;
  logic [W-1:0]  out0, out1;
  logic          busy, error;

  int errors = 0;
  int checks = 0;

  tc_ram_2r1w #(
    .UUID(0), .NAME("ram"), .BIT_WIDTH(W), .BIT_DEPTH(D), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .load0(load0), .address0(address0), .out0(out0),
    .load1(load1), .address1(address1), .out1(out1),
    .save(save), .save_address(save_address), .in(din), .byte_en(byte_en),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Behavioural model: word array, count of clear edges done, expected outputs.
  logic [W-1:0] m_mem [D];
  logic [W-1:0] m_out0, m_out1;
  logic         m_err;
  int           m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out0 = '0;
    m_out1 = '0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_read(input logic ld, input logic [15:0] a, output logic [W-1:0] q);
    q = '0;
    if (ld) begin
      if (int'(a) < D) q = m_mem[int'(a)];
      else m_err = 1'b1;
    end
  endtask

  // One rising edge: clear a word while clearing, else write first then read.
  task automatic model_edge();
    if (!rst) return;
    if (m_cnt < D) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      m_out0 = '0;
      m_out1 = '0;
      return;
    end
    if (save) begin
      if (int'(save_address) < D) begin
        for (int k = 0; k < NB; k++)
          if (byte_en[k]) m_mem[int'(save_address)][8*k +: 8] = din[8*k +: 8];
      end else begin
        m_err = 1'b1;
      end
    end
    model_read(load0, address0, m_out0);
    model_read(load1, address1, m_out1);
  endtask

  task automatic compare_all();
    check("out0",  out0,  m_out0);
    check("out1",  out1,  m_out1);
    check("busy",  busy,  m_cnt < D);
    check("error", error, m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    load0 = 0; load1 = 0; save = 0;
    address0 = '0; address1 = '0; save_address = '0;
    din = '0; byte_en = '0;
  endtask

  task automatic randomize_inputs(input int max_addr);
    load0        = 1'($urandom);
    load1        = 1'($urandom);
    save         = 1'($urandom);
    address0     = 16'($urandom_range(0, max_addr));
    address1     = 16'($urandom_range(0, max_addr));
    save_address = 16'($urandom_range(0, max_addr));
    din          = W'($urandom);
    byte_en      = NB'($urandom);
  endtask

  task automatic read0(input int a);
    quiet();
    load0 = 1; address0 = 16'(a);
    step();
  endtask

  task automatic write(input int a, input logic [W-1:0] d, input logic [NB-1:0] be);
    quiet();
    save = 1; save_address = 16'(a); din = d; byte_en = be;
    step();
  endtask

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("rst_out0", out0, 0);
    check("rst_out1", out1, 0);
    check("rst_busy", busy, 1);
    check("rst_error", error, 0);
    compare_all();
    step();
    rst = 1'b1;

    // Clear: busy for exactly D edges; save/load during clear have no effect
    for (int i = 1; i <= D; i++) begin
      randomize_inputs(D + 1);
      save = 1; save_address = 16'd2; din = 16'hBEEF; byte_en = '1;
      step();
      check("clear_busy", busy, i < D);
      check("clear_out0", out0, 0);
    end
    for (int a = 0; a < D; a++) begin
      read0(a);
      check("clear_word", out0, 0);
    end
    check("clear_no_error", error, 0);

    // Byte masking
    write(3, 16'hABCD, 2'b11);
    write(3, 16'h1234, 2'b01);
    read0(3);
    check("byte_mask", out0, 16'hAB34);

    // Dual read with forwarding on the same address
    write(5, 16'h1111, 2'b11);
    quiet();
    load0 = 1; load1 = 1; address0 = 16'd5; address1 = 16'd5;
    save = 1; save_address = 16'd5; din = 16'h2222; byte_en = 2'b10;
    step();
    check("fwd_out0", out0, 16'h2211);
    check("fwd_out1", out1, 16'h2211);
    read0(5);
    check("fwd_stored", out0, 16'h2211);

    // Load gating
    quiet();
    address0 = 16'd3;
    step();
    check("load_gate", out0, 0);

    // Out of range: dropped write, zero read, sticky error
    write(9, 16'hFFFF, 2'b11);
    check("oor_write_err", error, 1);
    read0(8);
    check("oor_read_out", out0, 0);
    check("oor_read_err", error, 1);
    for (int a = 0; a < D; a++) read0(a);
    read0(3);
    check("oor_intact", out0, 16'hAB34);

    // Random traffic, mostly in range
    for (int i = 0; i < 400; i++) begin
      randomize_inputs(D + 1);
      step();
    end
    quiet();
    step();
    check("sticky_error", error, 1);

    // Reset mid-clear at pointer 4
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      randomize_inputs(D + 1);
      step();
    end
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("midclr_err", error, 0);
    check("midclr_busy", busy, 1);
    randomize_inputs(D + 1);
    step();
    rst = 1'b1;
    for (int i = 1; i <= D; i++) begin
      randomize_inputs(D + 1);
      step();
      check("restart_busy", busy, i < D);
      check("restart_out0", out0, 0);
      check("restart_out1", out1, 0);
    end
    for (int a = 0; a < D; a++) begin
      read0(a);
      check("restart_word", out0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tc_ram_2r1w.md
# tc_ram_2r1w

Parametrised two-read/one-write word memory for the TC-to-Verilog component library, generalising the single-port byte-file ROM: same `UUID`/`NAME`/`BIT_WIDTH`/`BIT_DEPTH` parameter set, plus the behaviour a writable program/data RAM needs:

- two independent synchronous read ports;
- byte-enable writes on the rising clock edge;
- write-first forwarding;
- a post-reset clear sequencer;
- out-of-range detection.

It sits wherever a generated circuit instantiates a RAM component with more than one read port.

## Interface
Parameters:
- `UUID`, 0, component id emitted by the generator (unused in logic)
- `NAME`, "", component name emitted by the generator (unused in logic)
- `BIT_WIDTH`, 16, word width in bits; multiple of 8, range 8..64
- `BIT_DEPTH`, 256, number of words; range 2..65536
- `CLEAR_ON_RESET`, 1, 1 = zero every word after reset, 0 = skip clear (contents undefined)

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `load0`  in  1  read-enable, port 0
- `address0`  in  16  read address, port 0
- `out0`  out  BIT_WIDTH  registered read data, port 0
- `load1`  in  1  read-enable, port 1
- `address1`  in  16  read address, port 1
- `out1`  out  BIT_WIDTH  registered read data, port 1
- `save`  in  1  write-enable
- `save_address`  in  16  write address
- `in`  in  BIT_WIDTH  write data
- `byte_en`  in  BIT_WIDTH/8  per-byte write mask; bit k covers `in[8k+7:8k]`
- `busy`  out  1  high while clear sequence runs
- `error`  out  1  sticky out-of-range flag

## Operation
FSM with two states, CLEAR and IDLE.

Reset (`rst` low, asynchronous):
- `out0`, `out1` = 0; `error` = 0; clear pointer = 0.
- State = CLEAR with `busy` = 1 if `CLEAR_ON_RESET`=1; otherwise state = IDLE with `busy` = 0.
- Memory contents are not touched by reset itself.

CLEAR:
- Each edge writes 0 to `mem[ptr]`, then `ptr <= ptr+1`.
- The edge that writes `ptr == BIT_DEPTH-1` moves the FSM to IDLE; `busy` falls on that same edge.
- `save` is ignored (dropped, no error).
- Read ports register 0 regardless of `load`.

IDLE, read port N (0 and 1 fully independent, may hit the same address):
- `loadN`=1 and `addressN < BIT_DEPTH`: `outN <= mem[addressN]`.
- `loadN`=0: `outN <= 0`.
- `loadN`=1 and `addressN >= BIT_DEPTH`: `outN <= 0` and `error <= 1`.

IDLE, write port:
- `save`=1 and `save_address < BIT_DEPTH`: for each k with `byte_en[k]`=1, `mem[save_address]` byte k <= `in` byte k; other bytes are kept.
- `save`=1 and `save_address >= BIT_DEPTH`: write dropped, `error <= 1`.
- `save`=1 with `byte_en`=0: no change, no error unless out of range.

Forwarding (write-first): if a read port has `load`=1 and its address equals `save_address` in the same cycle, `outN` gets the merged word (enabled bytes from `in`, the rest from `mem`).

Error handling: `error` is cleared only by reset.

## Timing
- Read latency is exactly 1 cycle: data for the address/load presented before edge E appears after E.
- Write latency: visible to a non-forwarded read issued on the next cycle.
- Clear duration: exactly `BIT_DEPTH` rising edges after `rst` deasserts. The first edge with `rst` high writes word 0. The first IDLE-mode access is on edge `BIT_DEPTH+1`.
- Reset asserted mid-clear or mid-operation: the FSM restarts CLEAR from pointer 0. Any write on the edge concurrent with reset assertion is lost.
- Asynchronous `rst` deassertion must meet recovery time to `clk`. A synchroniser lives outside this block.

## Test plan
- Clear (BIT_WIDTH=16, BIT_DEPTH=8):
  - stimulus: release reset;
  - required: `busy`=1 for 8 edges, then 0; reads of addresses 0..7 all return 0x0000.
- Byte masking (IDLE):
  - stimulus: write 0xABCD to addr 3 with `byte_en`=2'b11, then 0x1234 with 2'b01;
  - required: read addr 3 returns 0xAB34 one cycle later.
- Dual read with forwarding:
  - stimulus: addr 5 holds 0x1111; in one cycle `load0`=`load1`=1, both addresses 5, `save` 0x2222 to addr 5 with mask 2'b10;
  - required: `out0`=`out1`=0x2211.
- Out of range (BIT_DEPTH=8):
  - stimulus: `save` to addr 9, then `load0` at addr 8;
  - required: no word changes, `out0`=0, `error`=1 and stays set until reset.
- Load gating and clear-time isolation:
  - stimulus: `load0`=0 reading a nonzero word; `save`/`load` asserted while `busy`=1;
  - required: out=0 in both cases, and the word at the `save` address is 0 after clear completes.
- Reset mid-clear:
  - stimulus: assert `rst` low at clear pointer 4, release;
  - required: `busy` high for a full 8 more edges, outputs 0 throughout.
